// File: rtl/fw_config_sequencer.sv
// Firmware config sequencer: drains the trace pipeline, drops tracing, streams staged
// bytes per block on configId/configData, then restores tracing. Optional: CFG_CHECKSUM_EN.
module fw_config_sequencer #(
  parameter int unsigned NUM_BLOCKS      = 4,
  parameter int unsigned BYTES_PER_BLOCK = 12,
  parameter int unsigned BASE_ID         = 1,
  parameter logic [7:0]  IDLE_ID         = 8'hFF,
  parameter int unsigned DRAIN_CYCLES    = 8,
  localparam int unsigned BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  localparam int unsigned IDX_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr_en,
  input  logic [BLK_W-1:0] cfg_wr_block,
  input  logic [IDX_W-1:0] cfg_wr_idx,
  input  logic [7:0]       cfg_wr_data,
  output logic             wr_reject,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             pipe_valid,
  output logic             tracing,
  output logic [7:0]       configId,
  output logic [7:0]       configData
`ifdef CFG_CHECKSUM_EN
  ,
  output logic [7:0]       checksum
`endif
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  // Staging table padded to powers of two so every index value is in bounds
  localparam int unsigned STG_B = 32'd1 << BLK_W;
  localparam int unsigned STG_K = 32'd1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_FLUSH, S_SEND, S_GAP, S_RESUME
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [BLK_W-1:0] r_blk, w_blk_nxt;
  logic [IDX_W-1:0] r_k, w_k_nxt;
  logic [DRN_W-1:0] r_drain, w_drain_nxt;
  logic             w_drain_done;

  logic [7:0]       r_stage [STG_B][STG_K];
  logic [7:0]       w_stage_byte;
  logic             w_wr_range_bad;
  logic             w_wr_ok;
  logic             w_wr_rej;

  logic             r_wr_reject;
  logic             r_busy;
  logic             r_done;
  logic             r_tracing;
  logic [7:0]       r_config_id;
  logic [7:0]       r_config_data;

  assign w_wr_range_bad = (32'(cfg_wr_idx) >= BYTES_PER_BLOCK) ||
                          (32'(cfg_wr_block) >= NUM_BLOCKS);
  assign w_wr_ok        = cfg_wr_en && (r_state == S_IDLE) && !w_wr_range_bad;
  assign w_wr_rej       = cfg_wr_en && ((r_state != S_IDLE) || w_wr_range_bad);
  assign w_stage_byte   = r_stage[w_blk_nxt][w_k_nxt];

  // Next-state and sequencing counters
  always_comb begin
    w_state_nxt  = r_state;
    w_blk_nxt    = r_blk;
    w_k_nxt      = r_k;
    w_drain_nxt  = r_drain;
    w_drain_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = '0;
        end
      end
      S_DRAIN: begin
        w_drain_nxt  = pipe_valid ? '0 : r_drain + 1'b1;
        w_drain_done = (DRAIN_CYCLES == 0) || (32'(w_drain_nxt) == DRAIN_CYCLES);
        if (w_drain_done) begin
          w_state_nxt = S_FLUSH;
          w_blk_nxt   = '0;
          w_k_nxt     = '0;
        end
      end
      S_FLUSH: w_state_nxt = S_SEND;
      S_SEND: begin
        if (r_k == IDX_W'(BYTES_PER_BLOCK - 1)) begin
          w_state_nxt = S_GAP;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_GAP: begin
        if (r_blk != BLK_W'(NUM_BLOCKS - 1)) begin
          w_state_nxt = S_SEND;
          w_blk_nxt   = r_blk + 1'b1;
          w_k_nxt     = '0;
        end else begin
          w_state_nxt = S_RESUME;
        end
      end
      S_RESUME: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and outputs; outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_blk         <= '0;
      r_k           <= '0;
      r_drain       <= '0;
      r_wr_reject   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tracing     <= 1'b1;
      r_config_id   <= IDLE_ID;
      r_config_data <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_blk         <= w_blk_nxt;
      r_k           <= w_k_nxt;
      r_drain       <= w_drain_nxt;
      r_wr_reject   <= w_wr_rej;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (w_state_nxt == S_RESUME);
      r_tracing     <= (w_state_nxt inside {S_IDLE, S_DRAIN, S_RESUME});
      r_config_id   <= (w_state_nxt == S_SEND) ? 8'(BASE_ID) + 8'(w_blk_nxt) : IDLE_ID;
      r_config_data <= (w_state_nxt == S_SEND) ? w_stage_byte : 8'h00;
    end
  end

  // Staging table, written by the host while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < int'(STG_B); b++) begin
        for (int k = 0; k < int'(STG_K); k++) begin
          r_stage[b][k] <= 8'h00;
        end
      end
    end else if (w_wr_ok) begin
      r_stage[cfg_wr_block][cfg_wr_idx] <= cfg_wr_data;
    end
  end

  assign wr_reject  = r_wr_reject;
  assign busy       = r_busy;
  assign done       = r_done;
  assign tracing    = r_tracing;
  assign configId   = r_config_id;
  assign configData = r_config_data;

`ifdef CFG_CHECKSUM_EN
  logic [7:0] r_csum_acc;
  logic [7:0] r_checksum;

  // Running XOR of streamed bytes, published on RESUME and held until next FLUSH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum_acc <= 8'h00;
      r_checksum <= 8'h00;
    end else if (w_state_nxt == S_FLUSH) begin
      r_csum_acc <= 8'h00;
      r_checksum <= 8'h00;
    end else if (w_state_nxt == S_SEND) begin
      r_csum_acc <= r_csum_acc ^ w_stage_byte;
    end else if (w_state_nxt == S_RESUME) begin
      r_checksum <= r_csum_acc;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_fw_config_sequencer.sv
// Self-checking bench for fw_config_sequencer: randomized staging/drain patterns checked
// cycle by cycle against a schedule model; also a minimal-parameter instance.
module tb_fw_config_sequencer;

  localparam int unsigned NB   = 4;
  localparam int unsigned BPB  = 12;
  localparam int unsigned DC   = 8;
  localparam int unsigned BASE = 1;
  localparam logic [7:0]  IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_wr_en;
  logic [1:0] cfg_wr_block;
  logic [3:0] cfg_wr_idx;
  logic [7:0] cfg_wr_data;
  logic       wr_reject;
  logic       start;
  logic       busy;
  logic       done;
  logic       pipe_valid;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;

  logic       s_wr_en;
  logic [0:0] s_wr_block;
  logic [0:0] s_wr_idx;
  logic [7:0] s_wr_data;
  logic       s_wr_reject;
  logic       s_start;
  logic       s_busy;
  logic       s_done;
  logic       s_pipe_valid;
  logic       s_tracing;
  logic [7:0] s_configId;
  logic [7:0] s_configData;
`ifdef CFG_CHECKSUM_EN
  logic [7:0] checksum;
  logic [7:0] s_checksum;
`endif

  always #5 clk = ~clk;

  fw_config_sequencer u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_block(cfg_wr_block), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_data(cfg_wr_data), .wr_reject(wr_reject),
    .start(start), .busy(busy), .done(done), .pipe_valid(pipe_valid),
    .tracing(tracing), .configId(configId), .configData(configData)
`ifdef CFG_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  fw_config_sequencer #(.NUM_BLOCKS(1), .BYTES_PER_BLOCK(1), .BASE_ID(1),
                        .IDLE_ID(8'hFF), .DRAIN_CYCLES(0)) u_small (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(s_wr_en), .cfg_wr_block(s_wr_block), .cfg_wr_idx(s_wr_idx),
    .cfg_wr_data(s_wr_data), .wr_reject(s_wr_reject),
    .start(s_start), .busy(s_busy), .done(s_done), .pipe_valid(s_pipe_valid),
    .tracing(s_tracing), .configId(s_configId), .configData(s_configData)
`ifdef CFG_CHECKSUM_EN
    , .checksum(s_checksum)
`endif
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] stg [NB][BPB];
  bit         pv_sched [64];
  logic [7:0] last_csum = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit pv_at(input int c);
    return (c >= 0 && c < 64) ? pv_sched[c] : 1'b0;
  endfunction

  task automatic clear_pv();
    for (int i = 0; i < 64; i++) pv_sched[i] = 1'b0;
  endtask

  // Host staging write issued while idle; model keeps only in-range bytes
  task automatic stage_write(input int b, input int k, input logic [7:0] d);
    cfg_wr_en    = 1'b1;
    cfg_wr_block = 2'(b);
    cfg_wr_idx   = 4'(k);
    cfg_wr_data  = d;
    step();
    cfg_wr_en = 1'b0;
    if (k < int'(BPB) && b < int'(NB)) stg[b][k] = d;
    check($sformatf("wr_reject_b%0d_k%0d", b, k), 32'(wr_reject), 32'(k >= int'(BPB)));
  endtask

  task automatic fill_random();
    for (int b = 0; b < int'(NB); b++)
      for (int k = 0; k < int'(BPB); k++)
        stage_write(b, k, 8'($urandom));
  endtask

  // One full sequence; cycle 0 is the start cycle. Optional injections:
  // inj_wr = cycle of a (rejected) busy write, inj_start = cycle of a busy start,
  // abort_at = return right after checking that cycle, same_wr = write with start.
  task automatic run_seq(input int inj_wr, input int inj_start, input int abort_at,
                         input bit same_wr);
    int         f, r, zeros, lows, dones, first_low, o, b, k;
    logic [7:0] prev_csum, new_csum, eid, edt;
    logic       etr, ebusy, edone, erej;
    logic [19:0] obs, exp;

    prev_csum  = last_csum;
    start      = 1'b1;
    pipe_valid = pv_at(0);
    if (same_wr) begin
      cfg_wr_en    = 1'b1;
      cfg_wr_block = 2'd3;
      cfg_wr_idx   = 4'd11;
      cfg_wr_data  = 8'($urandom);
      stg[3][11]   = cfg_wr_data;
    end
    f = 0;
    zeros = 0;
    for (int c = 1; c < 200 && f == 0; c++) begin
      if (pv_at(c)) zeros = 0; else zeros++;
      if (zeros >= int'(DC)) f = c + 1;
    end
    r = f + 1 + int'(NB) * (int'(BPB) + 1);
    new_csum = 8'h00;
    for (int bb = 0; bb < int'(NB); bb++)
      for (int kk = 0; kk < int'(BPB); kk++)
        new_csum ^= stg[bb][kk];
    step();
    start = 1'b0;
    cfg_wr_en = 1'b0;
    lows = 0;
    dones = 0;
    first_low = -1;
    for (int c = 1; c <= r + 1; c++) begin
      etr = 1'b0; ebusy = 1'b1; edone = 1'b0; eid = IDLE; edt = 8'h00;
      if (c < f) etr = 1'b1;
      else if (c > f && c < r) begin
        o = c - f - 1;
        b = o / (int'(BPB) + 1);
        k = o % (int'(BPB) + 1);
        if (k < int'(BPB)) begin
          eid = 8'(BASE + b);
          edt = stg[b][k];
        end
      end else if (c == r) begin
        etr = 1'b1; edone = 1'b1;
      end else if (c > r) begin
        etr = 1'b1; ebusy = 1'b0;
      end
      erej = (inj_wr >= 1 && c == inj_wr + 1);
      obs = {tracing, busy, done, wr_reject, configId, configData};
      exp = {etr, ebusy, edone, erej, eid, edt};
      check($sformatf("seq_c%0d", c), 32'(obs), 32'(exp));
`ifdef CFG_CHECKSUM_EN
      if (c < f)  check($sformatf("csum_held_c%0d", c), 32'(checksum), 32'(prev_csum));
      if (c >= r) check($sformatf("csum_c%0d", c), 32'(checksum), 32'(new_csum));
`endif
      if (!tracing) begin
        lows++;
        if (first_low < 0) first_low = c;
      end
      if (done) dones++;
      if (c == abort_at) return;
      pipe_valid = pv_at(c);
      cfg_wr_en  = (c == inj_wr);
      if (c == inj_wr) begin
        cfg_wr_block = 2'd2;
        cfg_wr_idx   = 4'd3;
        cfg_wr_data  = ~stg[2][3];
      end
      start = (c == inj_start);
      step();
    end
    cfg_wr_en  = 1'b0;
    start      = 1'b0;
    pipe_valid = 1'b0;
    last_csum  = new_csum;
    check("flush_at", 32'(first_low), 32'(f));
    check("low_cycles", 32'(lows), 32'(1 + NB * (BPB + 1)));
    check("done_pulses", 32'(dones), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("idle_after", 32'({tracing, busy, done, configId}), 32'({1'b1, 1'b0, 1'b0, IDLE}));
      step();
    end
  endtask

  logic [12:0] s_exp [6];
  logic [7:0]  s_byte;
  int          s_lows;
  int          abort_c;

  initial begin
    rst_n = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_block = '0; cfg_wr_idx = '0; cfg_wr_data = '0;
    start = 1'b0; pipe_valid = 1'b0;
    s_wr_en = 1'b0; s_wr_block = '0; s_wr_idx = '0; s_wr_data = '0;
    s_start = 1'b0; s_pipe_valid = 1'b0;
    for (int b = 0; b < int'(NB); b++)
      for (int k = 0; k < int'(BPB); k++)
        stg[b][k] = 8'h00;
    clear_pv();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({tracing, busy, done, wr_reject, configId, configData}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, IDLE, 8'h00}));
`ifdef CFG_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'h0);
`endif
    rst_n = 1'b1;
    step();

    // Basic sequence with staging[b][k] = 16*b + k
    for (int b = 0; b < int'(NB); b++)
      for (int k = 0; k < int'(BPB); k++)
        stage_write(b, k, 8'(16 * b + k));
    run_seq(-1, -1, -1, 1'b0);

    // Drain restart: pipe_valid on cycles 3 and 9 pushes FLUSH to cycle 18
    pv_sched[3] = 1'b1;
    pv_sched[9] = 1'b1;
    run_seq(-1, -1, -1, 1'b0);
    clear_pv();

    // Rejects: out-of-range index, write during SEND, start while busy
    stage_write(0, 12, 8'h5A);
    stage_write(3, 15, 8'hA5);
    run_seq(15, 30, -1, 1'b0);
    run_seq(-1, -1, -1, 1'b0);

    // Randomized staging and drain patterns, write coinciding with start
    for (int t = 0; t < 3; t++) begin
      fill_random();
      for (int i = 0; i < 40; i++) pv_sched[i] = ($urandom_range(0, 3) == 0);
      run_seq(-1, -1, -1, 1'b1);
      clear_pv();
    end

    // Reset mid-SEND at byte 5 of block 1, then a full sequence
    fill_random();
    abort_c = int'(DC) + 1 + 1 + (int'(BPB) + 1) + 5;
    run_seq(-1, -1, abort_c, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({tracing, busy, done, configId, configData}),
          32'({1'b1, 1'b0, 1'b0, IDLE, 8'h00}));
`ifdef CFG_CHECKSUM_EN
    check("midrst_checksum", 32'(checksum), 32'h0);
`endif
    for (int b = 0; b < int'(NB); b++)
      for (int k = 0; k < int'(BPB); k++)
        stg[b][k] = 8'h00;
    last_csum = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    fill_random();
    run_seq(-1, -1, -1, 1'b0);

    // Minimal instance: 1 block, 1 byte, no drain wait; write lands with start
    s_byte = 8'($urandom);
    s_exp[0] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, IDLE};
    s_exp[1] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE};
    s_exp[2] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01};
    s_exp[3] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE};
    s_exp[4] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};
    s_exp[5] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
    s_wr_en = 1'b1; s_wr_data = s_byte; s_start = 1'b1;
    step();
    s_wr_en = 1'b0; s_start = 1'b0;
    s_lows = 0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("small_c%0d", c + 1),
            32'({s_tracing, s_busy, s_done, s_wr_reject, s_configId}), 32'(s_exp[c][12:4] == 9'h0 ? 9'h0 : {s_exp[c][12:9], s_exp[c][7:0]}));
      check($sformatf("small_data_c%0d", c + 1), 32'(s_configData),
            32'((c == 2) ? s_byte : 8'h00));
      if (!s_tracing) s_lows++;
      step();
    end
    check("small_low_cycles", 32'(s_lows), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
